// File: rtl/tdm_deserializer8_if.sv
// Serial-link and parallel-word signal bundle for tdm_deserializer8.
// The slave modport is the receiver side and the master modport is the driver side.
interface tdm_deserializer8_if;
  logic       iSer;
  logic       iSync;
  logic       iEn;
  logic [3:0] oSlot;
  logic       oBusy;
  logic [7:0] oData;
  logic       oValid;
  logic       oErr;

  modport slave  (input  iSer, iSync, iEn,
                  output oSlot, oBusy, oData, oValid, oErr);
  modport master (output iSer, iSync, iEn,
                  input  oSlot, oBusy, oData, oValid, oErr);
endinterface

// File: rtl/tdm_deserializer8.sv
// Framed TDM receiver: reassembles 8 serial slots into a word with a valid/err strobe.
// Define TDM_PARITY_EN to add a ninth, even-parity slot.
module tdm_deserializer8 (
  input  logic                 iClk,
  input  logic                 iRst,
  tdm_deserializer8_if.slave   bus
);

  typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;

`ifdef TDM_PARITY_EN
  localparam logic [3:0] LAST = 4'd8;
`else
  localparam logic [3:0] LAST = 4'd7;
`endif

  state_t     state, stateN;
  logic [3:0] slot, slotN;
  logic [7:0] shadow, shadowN;
  logic [7:0] data, dataN;
  logic       valid, validN;
  logic       err, errN;
  logic [7:0] word;
`ifdef TDM_PARITY_EN
  logic       parOk;
`endif

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state  <= IDLE;
      slot   <= 4'd0;
      shadow <= 8'h00;
      data   <= 8'h00;
      valid  <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= stateN;
      slot   <= slotN;
      shadow <= shadowN;
      data   <= dataN;
      valid  <= validN;
      err    <= errN;
    end
  end

  always_comb begin
    stateN  = state;
    slotN   = slot;
    shadowN = shadow;
    dataN   = data;
    validN  = 1'b0;
    errN    = 1'b0;
    // Shadow with the current bit merged in; only meaningful for data slots.
    word    = shadow;
    if (!slot[3]) word[slot[2:0]] = bus.iSer;
`ifdef TDM_PARITY_EN
    parOk   = ~(^shadow ^ bus.iSer);
`endif
    if (bus.iEn) begin
      case (state)
        IDLE: begin
          if (bus.iSync) begin
            shadowN[0] = bus.iSer;
            slotN      = 4'd1;
            stateN     = RECV;
          end
        end
        RECV: begin
          if (bus.iSync) begin
            // Resync: drop the partial word, current bit becomes slot 0.
            errN       = 1'b1;
            shadowN[0] = bus.iSer;
            slotN      = 4'd1;
          end else if (slot == LAST) begin
            stateN = IDLE;
            slotN  = 4'd0;
`ifdef TDM_PARITY_EN
            if (parOk) begin
              dataN  = shadow;
              validN = 1'b1;
            end else begin
              errN   = 1'b1;
            end
`else
            dataN  = word;
            validN = 1'b1;
`endif
          end else begin
            shadowN = word;
            slotN   = slot + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.oSlot  = slot;
  assign bus.oBusy  = (state == RECV);
  assign bus.oData  = data;
  assign bus.oValid = valid;
  assign bus.oErr   = err;

endmodule

// File: tb/tb_tdm_deserializer8.sv
// Directed plus random bench for tdm_deserializer8 against a queue-based frame model.
// Builds with or without TDM_PARITY_EN.
module tb_tdm_deserializer8;

`ifdef TDM_PARITY_EN
  localparam int FRAME = 9;
`else
  localparam int FRAME = 8;
`endif

  logic iClk = 1'b0;
  logic iRst = 1'b0;
  tdm_deserializer8_if bus();

  tdm_deserializer8 dut (.iClk(iClk), .iRst(iRst), .bus(bus));

  always #5 iClk = ~iClk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int validCnt = 0;
  int errCnt = 0;
  int lastValidCyc = 0;
  int validGap = 0;

  // Model: bits received since the last sync, oldest first.
  bit         q[$];
  logic [7:0] expData = 8'h00;
  logic       expValid = 1'b0;
  logic       expErr = 1'b0;

  task automatic checkEq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelEdge(input logic en, input logic sync, input logic ser);
    logic [7:0] w;
    bit par;
    expValid = 1'b0;
    expErr   = 1'b0;
    if (en) begin
      if (sync) begin
        if (q.size() > 0) expErr = 1'b1;
        q.delete();
        q.push_back(ser);
      end else if (q.size() > 0) begin
        q.push_back(ser);
        if (q.size() == FRAME) begin
          w = 8'h00;
          par = 1'b0;
          foreach (q[k]) begin
            if (k < 8) w[k] = q[k];
            par ^= q[k];
          end
          if (FRAME == 8 || par == 1'b0) begin
            expData  = w;
            expValid = 1'b1;
          end else begin
            expErr = 1'b1;
          end
          q.delete();
        end
      end
    end
  endtask

  task automatic checkAll();
    checkEq("slot",  {4'd0, bus.oSlot}, 8'(q.size()));
    checkEq("busy",  {7'd0, bus.oBusy}, {7'd0, q.size() != 0});
    checkEq("data",  bus.oData, expData);
    checkEq("valid", {7'd0, bus.oValid}, {7'd0, expValid});
    checkEq("err",   {7'd0, bus.oErr}, {7'd0, expErr});
  endtask

  task automatic step(input logic en, input logic sync, input logic ser);
    bus.iEn = en; bus.iSync = sync; bus.iSer = ser;
    @(posedge iClk);
    cyc++;
    modelEdge(en, sync, ser);
    #1;
    if (bus.oValid === 1'b1) begin
      validGap = cyc - lastValidCyc;
      lastValidCyc = cyc;
      validCnt++;
    end
    if (bus.oErr === 1'b1) errCnt++;
    checkAll();
  endtask

  task automatic doReset();
    iRst = 1'b1;
    bus.iEn = 1'b0; bus.iSync = 1'b0; bus.iSer = 1'b0;
    @(posedge iClk);
    cyc++;
    q.delete();
    expData = 8'h00; expValid = 1'b0; expErr = 1'b0;
    #1;
    iRst = 1'b0;
    checkAll();
  endtask

  function automatic logic slotBit(input logic [7:0] w, input int k, input logic flip);
    if (k < 8) return w[k];
    return (^w) ^ flip;
  endfunction

  // Sends slots 0..nSlots-1 of word w, sync on slot 0.
  task automatic sendFrame(input logic [7:0] w, input int nSlots, input logic flip);
    for (int k = 0; k < nSlots; k++) step(1'b1, k == 0, slotBit(w, k, flip));
  endtask

  initial begin
    bus.iEn = 1'b0; bus.iSync = 1'b0; bus.iSer = 1'b0;

    // Reset state
    doReset();
    checkEq("rstData", bus.oData, 8'h00);

    // Frame A5
    validCnt = 0;
    sendFrame(8'hA5, FRAME, 1'b0);
    checkEq("a5Data", bus.oData, 8'hA5);
    checkEq("a5Valid", {7'd0, bus.oValid}, 8'd1);
    checkEq("a5Slot", {4'd0, bus.oSlot}, 8'd0);
    step(1'b0, 1'b0, 1'b0);
    checkEq("a5ValidCnt", 8'(validCnt), 8'd1);

    // Gapped enable: 3C with two idle enables after slot 3
    validCnt = 0;
    sendFrame(8'h3C, 4, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    checkEq("gapSlot0", {4'd0, bus.oSlot}, 8'd4);
    step(1'b0, 1'b1, 1'b1);
    checkEq("gapSlot1", {4'd0, bus.oSlot}, 8'd4);
    for (int k = 4; k < FRAME; k++) step(1'b1, 1'b0, slotBit(8'h3C, k, 1'b0));
    checkEq("gapData", bus.oData, 8'h3C);
    checkEq("gapValidCnt", 8'(validCnt), 8'd1);

    // Framing error at slot 5, then FF
    validCnt = 0; errCnt = 0;
    sendFrame(8'h00, 5, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    checkEq("ferrErr", {7'd0, bus.oErr}, 8'd1);
    checkEq("ferrValid", {7'd0, bus.oValid}, 8'd0);
    checkEq("ferrData", bus.oData, 8'h3C);
    for (int k = 1; k < FRAME; k++) step(1'b1, 1'b0, slotBit(8'hFF, k, 1'b0));
    checkEq("ferrFF", bus.oData, 8'hFF);
    checkEq("ferrCnts", 8'({validCnt[3:0], errCnt[3:0]}), 8'h11);

    // Back-to-back 01 then 80
    validCnt = 0;
    sendFrame(8'h01, FRAME, 1'b0);
    checkEq("b2bFirst", bus.oData, 8'h01);
    sendFrame(8'h80, FRAME, 1'b0);
    checkEq("b2bSecond", bus.oData, 8'h80);
    checkEq("b2bGap", 8'(validGap), 8'(FRAME));
    checkEq("b2bCnt", 8'(validCnt), 8'd2);

    // Reset mid-frame
    validCnt = 0; errCnt = 0;
    sendFrame(8'h55, 5, 1'b0);
    doReset();
    checkEq("mrstData", bus.oData, 8'h00);
    checkEq("mrstBusy", {7'd0, bus.oBusy}, 8'd0);
    sendFrame(8'h0F, FRAME, 1'b0);
    checkEq("mrstNext", bus.oData, 8'h0F);
    checkEq("mrstCnts", 8'({validCnt[3:0], errCnt[3:0]}), 8'h10);

`ifdef TDM_PARITY_EN
    validCnt = 0; errCnt = 0;
    sendFrame(8'hA5, FRAME, 1'b0);
    checkEq("parOkData", bus.oData, 8'hA5);
    checkEq("parOkValid", {7'd0, bus.oValid}, 8'd1);
    sendFrame(8'h5A, FRAME, 1'b1);
    checkEq("parBadErr", {7'd0, bus.oErr}, 8'd1);
    checkEq("parBadValid", {7'd0, bus.oValid}, 8'd0);
    checkEq("parBadData", bus.oData, 8'hA5);
    checkEq("parBadSlot", {4'd0, bus.oSlot}, 8'd0);
`endif

    // Random frames and noise
    for (int n = 0; n < 40; n++) begin
      logic [7:0] w;
      w = 8'($urandom);
      sendFrame(w, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, FRAME)) : FRAME,
                1'($urandom_range(0, 5) == 0));
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) step(1'b1, 1'b0, 1'($urandom));
    end
    for (int n = 0; n < 600; n++)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0), 1'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tdm_deserializer8.md
# tdm_deserializer8

Receive-side sequential counterpart of the 8-bit select-line transmission path. It takes one serial bit per enabled slot on a single wire and a frame-sync pulse that marks slot 0, and counts slots internally. It reassembles an 8-bit word and presents it with a one-cycle valid strobe. It sits between the serial link and the parallel consumer, replacing the combinational demultiplexer with a framed, clocked receiver.

## Interface
Parameters: none.

Ports:
- iClk input 1: sole clock; all state updates on the rising edge.
- iRst input 1: reset, synchronous, active-high.
- iSer input 1: serial data bit for the current slot.
- iSync input 1: frame start; high in the same enabled cycle as slot-0 bit.
- iEn input 1: slot strobe; bits sampled only when high, all state held when low.
- oSlot output 4: index of the slot expected at next enabled cycle; [3] is always 0 unless parity built in.
- oBusy output 1: high while a frame is partially received.
- oData output 8: last completed word; slot k bit lands in oData[k].
- oValid output 1: one-cycle pulse, oData updated this cycle.
- oErr output 1: one-cycle pulse on framing (or parity) error.

## Operation
- States: IDLE, RECV.
- IDLE: oSlot=0, oBusy=0. Enabled cycle with iSync=1 stores iSer into shadow[0], sets slot=1, and moves to RECV. Enabled cycle with iSync=0 is ignored, with no error.
- RECV: each enabled cycle with iSync=0 stores iSer into shadow[slot] and increments slot.
- Final slot (7, or 8 with parity): the word is committed, oValid pulses, and the block returns to IDLE with slot=0.
- iSync=1 in RECV with slot≠0: framing error. oErr pulses, the partial word is discarded with oData unchanged, and the current bit is taken as the new slot 0 (slot=1, stay RECV).
- Back-to-back frames: iSync on the enabled cycle right after the final slot starts a new frame with no gap.
- iEn=0: shadow, slot, and state are frozen. oValid and oErr are pulses only, so they return to 0.
- Shadow register is internal; oData changes only on a committed word.

## Timing
- Reset values: state IDLE, oSlot=0, oBusy=0, oData=8'h00, oValid=0, oErr=0, and shadow cleared.
- Reset asserted mid-frame aborts the frame at the next edge. No oValid and no oErr are produced for that frame.
- Latency: oData/oValid become visible on the edge that samples the final-slot bit. They are observable in the cycle after that bit is presented.
- Minimum frame: 8 enabled cycles (9 with parity). Throughput is one word per 8 (9) enabled cycles.
- oValid and oErr are never high in the same cycle. A framing error takes priority and the aborted frame never commits.
- oSlot and oBusy are registered, with no combinational path from inputs.

## Configuration
- Macro TDM_PARITY_EN.
- Defined: slot 8 carries an even-parity bit over the 8 data bits; oSlot counts 0..8.
  - Parity match at slot 8 commits oData and pulses oValid.
  - Mismatch pulses oErr, suppresses oValid, and leaves oData unchanged.
  - The block returns to IDLE in both cases.
- Undefined: 8 slots only, oSlot[3] tied 0, and oErr reports framing errors only.

## Test plan
- Reset then frame 8'hA5: drive iEn=1 and bits 1,0,1,0,0,1,0,1 (slot0 first) with iSync on the first. Expect oValid for 1 cycle, oData=8'hA5, and oSlot back to 0.
- Gapped enable: same word 8'h3C with iEn low for 2 cycles between slot 3 and 4. Expect oSlot to hold at 4 during the gap, then oData=8'h3C with oValid once.
- Framing error: iSync again at slot 5, followed by a full 8'hFF frame. Expect oErr pulse at the resync edge with no oValid, then oData=8'hFF.
- Back-to-back: 8'h01 then 8'h80 with no idle cycle. Expect two oValid pulses exactly 8 cycles apart, with oData=8'h01 then 8'h80.
- Reset mid-frame: iRst high after slot 4 of 8'h55. Expect all outputs at reset values, no oValid, and a following 8'h0F frame received correctly.
- TDM_PARITY_EN: 8'hA5 with parity bit 0 gives oValid and oData=8'hA5. The same frame with parity bit 1 gives oErr, no oValid, and oData unchanged.
